// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the ula_seq operand/opcode driver.
//   - ULA_DW       : ALU data width (only 4 is supported)
//   - OP_ADD..OP_NOT : 3-bit opcodes; bit0/1/2 map onto ALU select x/y/z
//   - state_t      : sequencer state encoding
package ula_pkg;

  localparam int ULA_DW = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/ula_seq_rf.sv
// ula_seq_rf: 2**REG_AW x DW register file for the ALU sequencer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset (clears all entries)
//   i_rd_addr_a/b, o_rd_data_a/b  two asynchronous read ports
//   i_wb_en/addr/data         ALU writeback port (wins on address collision)
//   i_ext_en/addr/data        external write port
import ula_pkg::*;

module ula_seq_rf #(
  parameter int REG_AW = 2,
  parameter int DW     = ULA_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_rd_addr_a,
  input  logic [REG_AW-1:0] i_rd_addr_b,
  output logic [DW-1:0]     o_rd_data_a,
  output logic [DW-1:0]     o_rd_data_b,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DW-1:0]     i_wb_data,
  input  logic              i_ext_en,
  input  logic [REG_AW-1:0] i_ext_addr,
  input  logic [DW-1:0]     i_ext_data
);

  localparam int N_REGS = 2**REG_AW;

  logic [DW-1:0] r_mem [N_REGS];

  // The writeback assignment comes last so it overrides an external write
  // to the same entry on the same edge; different entries both update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) r_mem[i] <= '0;
    end else begin
      if (i_ext_en) r_mem[i_ext_addr] <= i_ext_data;
      if (i_wb_en)  r_mem[i_wb_addr]  <= i_wb_data;
    end
  end

  assign o_rd_data_a = r_mem[i_rd_addr_a];
  assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/ula_seq.sv
// ula_seq: operand/opcode driver for the 4-bit ALU (ula).
// Accepts an instruction (IDLE), drives the ALU for one cycle (DRIVE),
// captures S into the register file and the result port, then holds the
// result until it is consumed (RESP).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   instr_valid/ready, instr_op/ra/rb/rd  instruction handshake
//   wr_en/addr/data                  external register write (any state)
//   alu_a/b, alu_x/y/z, alu_s        ALU interface (x/y/z = op bit 0/1/2)
//   res_valid/ready, res_data/rd     result handshake
//   err                              sticky self-check error
// Optional: define ULA_SEQ_CHECK_EN to build a reference model that flags
// any ALU result differing from the expected value; otherwise err is 0.
import ula_pkg::*;

module ula_seq #(
  parameter int REG_AW = 2,
  parameter int DW     = ULA_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [2:0]        alu_x,
  output logic [2:0]        alu_y,
  output logic [2:0]        alu_z,
  input  logic [DW-1:0]     alu_s,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW-1:0]     res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic              err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_wb_en;
  logic [DW-1:0]     w_rf_a;
  logic [DW-1:0]     w_rf_b;
  logic [DW-1:0]     r_alu_a;
  logic [DW-1:0]     r_alu_b;
  logic [2:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic              r_res_valid;
  logic [DW-1:0]     r_res_data;

  ula_seq_rf #(.REG_AW(REG_AW), .DW(DW)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_rd_addr_a(instr_ra),
    .i_rd_addr_b(instr_rb),
    .o_rd_data_a(w_rf_a),
    .o_rd_data_b(w_rf_b),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_rd),
    .i_wb_data  (alu_s),
    .i_ext_en   (wr_en),
    .i_ext_addr (wr_addr),
    .i_ext_data (wr_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    w_accept    = 1'b0;
    w_wb_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        w_accept    = instr_valid;
        if (instr_valid) w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        w_wb_en     = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands are sampled from the register file at accept; an external
  // write landing on the same edge is not forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_a <= w_rf_a;
        r_alu_b <= w_rf_b;
        r_op    <= instr_op;
        r_rd    <= instr_rd;
      end
      if (w_wb_en) begin
        r_res_data  <= alu_s;
        r_res_valid <= 1'b1;
      end else if (r_state == ST_RESP && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_x     = {2'b00, r_op[0]};
  assign alu_y     = {2'b00, r_op[1]};
  assign alu_z     = {2'b00, r_op[2]};
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_rd    = r_rd;

`ifdef ULA_SEQ_CHECK_EN
  logic r_err;

  // Shifts by b >= DW fall out of the DW-wide result and give 0.
  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic [2:0]    op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return a << b;
      OP_SHR:  return a >> b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~a;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_wb_en && (alu_s != ref_result(r_alu_a, r_alu_b, r_op))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed bench for ula_seq with a transaction-level model of
// the sequencer and a behavioural ALU closing the a/b/x/y/z -> S loop.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_ra, instr_rb, instr_rd;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] alu_a, alu_b, alu_s;
  logic [2:0] alu_x, alu_y, alu_z;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       err;

  logic [3:0] corrupt;
  bit         chk_on;
  int         n_cmp, n_bad;

  always #5 clk = ~clk;

  ula_seq #(.REG_AW(2), .DW(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
    .alu_s(alu_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .err(err)
  );

  // Plain-integer arithmetic view of the ALU, results modulo 16.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int ia, ib, r;
    ia = a; ib = b;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib + 16;
      3'd2: r = (ib >= 4) ? 0 : ia * (2 ** ib);
      3'd3: r = (ib >= 4) ? 0 : ia / (2 ** ib);
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: r = 15 - ia;
    endcase
    return 4'(r % 16);
  endfunction

  // Behavioural ALU; corrupt lets the bench inject a wrong S.
  always_comb alu_s = alu_ref(alu_a, alu_b, {alu_z[0], alu_y[0], alu_x[0]}) ^ corrupt;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // m_phase: 0 waiting for an instruction, 1 ALU computing, 2 result pending
  int         m_phase;
  logic [3:0] m_rf [4];
  logic [3:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic [1:0] m_rd;
  bit         m_err;
  bit         m_wb;
  logic [3:0] m_wbv;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_res = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_rf[i] = 0;
    end else begin
      m_wb = 0;
      m_wbv = 0;
      if (m_phase == 0) begin
        if (instr_valid) begin
          m_a = m_rf[instr_ra]; m_b = m_rf[instr_rb];
          m_op = instr_op; m_rd = instr_rd; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_wbv = alu_ref(m_a, m_b, m_op) ^ corrupt;
        m_wb = 1; m_res = m_wbv; m_phase = 2;
`ifdef ULA_SEQ_CHECK_EN
        if (corrupt != 0) m_err = 1;
`endif
      end else if (res_ready) begin
        m_phase = 0;
      end
      if (wr_en) m_rf[wr_addr] = wr_data;
      if (m_wb) m_rf[m_rd] = m_wbv;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("instr_ready", instr_ready, m_phase == 0);
      check("res_valid", res_valid, m_phase == 2);
      check("res_data", res_data, m_res);
      check("res_rd", res_rd, m_rd);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_x", alu_x, {2'b00, m_op[0]});
      check("alu_y", alu_y, {2'b00, m_op[1]});
      check("alu_z", alu_z, {2'b00, m_op[2]});
      check("err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk); wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic [3:0] exp, input bit early,
                       input int hold, input logic [3:0] cmask, input bit acc_wr,
                       input logic [1:0] acc_addr, input logic [3:0] acc_data,
                       input bit coll);
    int waits;
    @(negedge clk);
    instr_valid = 1; instr_op = op; instr_ra = ra; instr_rb = rb; instr_rd = rd;
    res_ready = early; corrupt = cmask;
    wr_en = acc_wr; wr_addr = acc_addr; wr_data = acc_data;
    @(negedge clk);
    instr_valid = 0; instr_op = 3'd7; instr_ra = 2'd3; instr_rb = 2'd3; instr_rd = 2'd0;
    wr_en = coll; wr_addr = rd; wr_data = 4'hF;
    waits = 0;
    while (!res_valid && waits < 8) begin
      @(negedge clk);
      wr_en = 0;
      waits++;
    end
    check("latency", 8'(waits), 8'd1);
    check("lit_res_data", res_data, exp);
    check("lit_res_rd", res_rd, rd);
    res_ready = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1'b1);
      check("hold_data", res_data, exp);
      check("hold_ready", instr_ready, 1'b0);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0; corrupt = 0;
    check("idle_after", instr_ready, 1'b1);
  endtask

  task automatic op_plain(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic [3:0] exp, input bit early);
    issue(op, ra, rb, rd, exp, early, 0, 4'h0, 0, 2'd0, 4'h0, 0);
  endtask

  initial begin
    rst = 1; instr_valid = 0; instr_op = 0; instr_ra = 0; instr_rb = 0; instr_rd = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; res_ready = 0; corrupt = 0;
    chk_on = 0; n_cmp = 0; n_bad = 0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_valid", res_valid, 1'b0);
    check("rst_data", res_data, 4'h0);
    check("rst_rd", res_rd, 2'd0);
    check("rst_alu_a", alu_a, 4'h0);
    check("rst_alu_x", alu_x, 3'd0);
    check("rst_err", err, 1'b0);
    rst = 0; chk_on = 1;

    wr(2'd0, 4'h5);
    wr(2'd1, 4'h3);
    op_plain(3'd0, 2'd0, 2'd1, 2'd2, 4'h8, 0);   // ADD 5+3
    op_plain(3'd5, 2'd2, 2'd2, 2'd3, 4'h8, 1);   // read back r2; early res_ready
    op_plain(3'd1, 2'd1, 2'd0, 2'd3, 4'hE, 0);   // SUB 3-5 wraps
    op_plain(3'd2, 2'd0, 2'd1, 2'd3, 4'h8, 1);   // SHL 5<<3
    wr(2'd1, 4'h4);
    op_plain(3'd3, 2'd0, 2'd1, 2'd3, 4'h0, 0);   // SHR by 4
    op_plain(3'd7, 2'd0, 2'd1, 2'd3, 4'hA, 0);   // NOT 5
    issue(3'd4, 2'd0, 2'd1, 2'd3, 4'h4, 0, 5, 4'h0, 0, 2'd0, 4'h0, 0);  // backpressure
    issue(3'd6, 2'd0, 2'd1, 2'd2, 4'h1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 1);  // collision on r2
    op_plain(3'd5, 2'd2, 2'd2, 2'd3, 4'h1, 0);   // r2 kept ALU result
    issue(3'd0, 2'd0, 2'd0, 2'd3, 4'hA, 0, 0, 4'h0, 1, 2'd0, 4'h7, 0);  // old r0 used
    op_plain(3'd5, 2'd0, 2'd0, 2'd3, 4'h7, 0);   // r0 now 7

    // reset while in DRIVE
    @(negedge clk);
    instr_valid = 1; instr_op = 3'd0; instr_ra = 2'd0; instr_rb = 2'd1; instr_rd = 2'd3;
    @(negedge clk);
    instr_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_ready", instr_ready, 1'b1);
    wr(2'd0, 4'h5);
    wr(2'd1, 4'h3);
    op_plain(3'd5, 2'd3, 2'd3, 2'd2, 4'h0, 0);   // r3 never written

    // corrupted ALU result
    issue(3'd0, 2'd0, 2'd1, 2'd2, 4'h9, 0, 0, 4'h1, 0, 2'd0, 4'h0, 0);
`ifdef ULA_SEQ_CHECK_EN
    check("err_set", err, 1'b1);
`else
    check("err_tied", err, 1'b0);
`endif
    op_plain(3'd5, 2'd2, 2'd2, 2'd3, 4'h9, 0);
`ifdef ULA_SEQ_CHECK_EN
    check("err_sticky", err, 1'b1);
`else
    check("err_tied2", err, 1'b0);
`endif
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    check("err_cleared", err, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
